// File: rtl/bck_slot_scheduler_pkg.sv
// Shared constants for the backward-extension slot scheduler: pipeline status
// codes, read id width, slot-state encodings and the slot context record.
package bck_slot_scheduler_pkg;

  localparam int NUM_SLOTS      = 4;
  localparam int SLOT_W         = 2;
  localparam int READ_NUM_WIDTH = 16;
  localparam int STATUS_W       = 6;

  localparam logic [STATUS_W-1:0] BUBBLE  = 6'd0;
  localparam logic [STATUS_W-1:0] BCK_INI = 6'd1;
  localparam logic [STATUS_W-1:0] BCK_RUN = 6'd2;

  localparam logic [1:0] SLOT_FREE      = 2'd0;
  localparam logic [1:0] SLOT_RDY_INI   = 2'd1;
  localparam logic [1:0] SLOT_IN_FLIGHT = 2'd2;
  localparam logic [1:0] SLOT_RDY_RUN   = 2'd3;

  typedef struct packed {
    logic [1:0]                state;
    logic [READ_NUM_WIDTH-1:0] read_num;
  } slot_t;

  // Status a ready slot carries into stage 1.
  function automatic logic [STATUS_W-1:0] status_for(input logic [1:0] state);
    return (state == SLOT_RDY_INI) ? BCK_INI : BCK_RUN;
  endfunction

endpackage

// File: rtl/bck_slot_scheduler_if.sv
// Parser / pipeline-tail / stage-1 signals of the slot scheduler.
interface bck_slot_scheduler_if;
  import bck_slot_scheduler_pkg::*;

  logic                      stall;
  logic                      new_valid;
  logic [READ_NUM_WIDTH-1:0] new_read_num;
  logic                      new_ready;
  logic                      ret_valid;
  logic [SLOT_W-1:0]         ret_slot;
  logic                      ret_done;
  logic [READ_NUM_WIDTH-1:0] issue_read_num;
  logic [SLOT_W-1:0]         issue_slot;
  logic [STATUS_W-1:0]       issue_status;
  logic                      done_valid;
  logic [READ_NUM_WIDTH-1:0] done_read_num;
  logic                      proto_err;

  modport master (
    output stall, new_valid, new_read_num, ret_valid, ret_slot, ret_done,
    input  new_ready, issue_read_num, issue_slot, issue_status,
           done_valid, done_read_num, proto_err
  );

  modport slave (
    input  stall, new_valid, new_read_num, ret_valid, ret_slot, ret_done,
    output new_ready, issue_read_num, issue_slot, issue_status,
           done_valid, done_read_num, proto_err
  );

endinterface

// File: rtl/bck_slot_scheduler_rr_pick.sv
// Combinational round-robin picker: first set bit of ready at or after ptr,
// wrapping around. N must be a power of two with W = log2(N).
module bck_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] ready,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [N-1:0] rot;
  logic [W-1:0] off;

  // rot[k] is the slot k positions after ptr; W-bit addition provides the wrap.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      assign rot[gi] = ready[ptr + W'(gi)];
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = W'(i);
      end
    end
  end

  assign idx = ptr + off;

endmodule

// File: rtl/bck_slot_scheduler.sv
// Holds NUM_SLOTS read contexts and injects one token per non-stalled cycle
// into stage 1, sharing the slots round-robin.
module bck_slot_scheduler
  import bck_slot_scheduler_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  bck_slot_scheduler_if.slave  bus
);

  slot_t slot_reg  [NUM_SLOTS];
  slot_t slot_next [NUM_SLOTS];

  logic [NUM_SLOTS-1:0]      free_vec;
  logic [NUM_SLOTS-1:0]      rdy_vec;
  logic                      alloc_found;
  logic [SLOT_W-1:0]         alloc_idx;
  logic                      issue_found;
  logic [SLOT_W-1:0]         issue_idx;
  logic                      alloc_fire;
  logic                      ret_ok;

  logic [SLOT_W-1:0]         rr_ptr_reg,         rr_ptr_next;
  logic                      new_ready_reg,      new_ready_next;
  logic [READ_NUM_WIDTH-1:0] issue_read_num_reg, issue_read_num_next;
  logic [SLOT_W-1:0]         issue_slot_reg,     issue_slot_next;
  logic [STATUS_W-1:0]       issue_status_reg,   issue_status_next;
  logic                      done_valid_reg,     done_valid_next;
  logic [READ_NUM_WIDTH-1:0] done_read_num_reg,  done_read_num_next;
  logic                      proto_err_reg,      proto_err_next;

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_vec
      assign free_vec[gi] = (slot_reg[gi].state == SLOT_FREE);
      assign rdy_vec[gi]  = (slot_reg[gi].state == SLOT_RDY_INI) ||
                            (slot_reg[gi].state == SLOT_RDY_RUN);
    end
  endgenerate

  // A picker anchored at 0 yields the lowest-index free slot.
  bck_rr_pick #(.N(NUM_SLOTS), .W(SLOT_W)) u_alloc_pick (
    .ready (free_vec),
    .ptr   (SLOT_W'(0)),
    .found (alloc_found),
    .idx   (alloc_idx)
  );

  bck_rr_pick #(.N(NUM_SLOTS), .W(SLOT_W)) u_issue_pick (
    .ready (rdy_vec),
    .ptr   (rr_ptr_reg),
    .found (issue_found),
    .idx   (issue_idx)
  );

  assign alloc_fire = bus.new_valid && new_ready_reg && alloc_found;
  assign ret_ok     = (slot_reg[bus.ret_slot].state == SLOT_IN_FLIGHT);

  // Allocation, issue and return always hit distinct slots, so their updates compose.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_next[i] = slot_reg[i];
    end
    rr_ptr_next         = rr_ptr_reg;
    issue_read_num_next = issue_read_num_reg;
    issue_slot_next     = issue_slot_reg;
    issue_status_next   = issue_status_reg;
    done_valid_next     = 1'b0;
    done_read_num_next  = done_read_num_reg;
    proto_err_next      = proto_err_reg;

    if (alloc_fire) begin
      slot_next[alloc_idx].state    = SLOT_RDY_INI;
      slot_next[alloc_idx].read_num = bus.new_read_num;
    end

    if (!bus.stall) begin
      if (issue_found) begin
        issue_read_num_next          = slot_reg[issue_idx].read_num;
        issue_slot_next              = issue_idx;
        issue_status_next            = status_for(slot_reg[issue_idx].state);
        slot_next[issue_idx].state   = SLOT_IN_FLIGHT;
        rr_ptr_next                  = issue_idx + SLOT_W'(1);
      end else begin
        issue_read_num_next = '0;
        issue_slot_next     = '0;
        issue_status_next   = BUBBLE;
      end
    end

    if (bus.ret_valid) begin
      if (ret_ok) begin
        if (bus.ret_done) begin
          slot_next[bus.ret_slot].state = SLOT_FREE;
          done_valid_next               = 1'b1;
          done_read_num_next            = slot_reg[bus.ret_slot].read_num;
        end else begin
          slot_next[bus.ret_slot].state = SLOT_RDY_RUN;
        end
      end else begin
        proto_err_next = 1'b1;
      end
    end

    new_ready_next = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_next[i].state == SLOT_FREE) begin
        new_ready_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_reg[i] <= '{state: SLOT_FREE, read_num: '0};
      end
      rr_ptr_reg         <= '0;
      new_ready_reg      <= 1'b1;
      issue_read_num_reg <= '0;
      issue_slot_reg     <= '0;
      issue_status_reg   <= BUBBLE;
      done_valid_reg     <= 1'b0;
      done_read_num_reg  <= '0;
      proto_err_reg      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_reg[i] <= slot_next[i];
      end
      rr_ptr_reg         <= rr_ptr_next;
      new_ready_reg      <= new_ready_next;
      issue_read_num_reg <= issue_read_num_next;
      issue_slot_reg     <= issue_slot_next;
      issue_status_reg   <= issue_status_next;
      done_valid_reg     <= done_valid_next;
      done_read_num_reg  <= done_read_num_next;
      proto_err_reg      <= proto_err_next;
    end
  end

  assign bus.new_ready      = new_ready_reg;
  assign bus.issue_read_num = issue_read_num_reg;
  assign bus.issue_slot     = issue_slot_reg;
  assign bus.issue_status   = issue_status_reg;
  assign bus.done_valid     = done_valid_reg;
  assign bus.done_read_num  = done_read_num_reg;
  assign bus.proto_err      = proto_err_reg;

endmodule

// File: tb/tb_bck_slot_scheduler.sv
// Directed scenarios plus randomized traffic for bck_slot_scheduler, checked
// against a slot-list reference model.
module tb_bck_slot_scheduler;
  import bck_slot_scheduler_pkg::*;

  localparam int M_FREE      = 0;
  localparam int M_RDY_INI   = 1;
  localparam int M_IN_FLIGHT = 2;
  localparam int M_RDY_RUN   = 3;

  logic clk;
  logic rst;

  bck_slot_scheduler_if bus ();

  bck_slot_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: per-slot lifecycle plus the expected output registers.
  int                  m_state [NUM_SLOTS];
  int                  m_id    [NUM_SLOTS];
  int                  m_rr;
  int                  m_issue_id;
  int                  m_issue_slot;
  logic [STATUS_W-1:0] m_issue_status;
  bit                  m_done_v;
  int                  m_done_id;
  bit                  m_perr;
  bit                  m_ready;

  int n_cand;
  int cand [NUM_SLOTS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_SLOTS; i++) begin
      m_state[i] = M_FREE;
      m_id[i]    = 0;
    end
    m_rr           = 0;
    m_issue_id     = 0;
    m_issue_slot   = 0;
    m_issue_status = BUBBLE;
    m_done_v       = 0;
    m_done_id      = 0;
    m_perr         = 0;
    m_ready        = 1;
  endtask

  task automatic model_edge();
    int  pre [NUM_SLOTS];
    int  s;
    bit  hit;
    for (int i = 0; i < NUM_SLOTS; i++) pre[i] = m_state[i];

    if (bus.new_valid && m_ready) begin
      hit = 0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (!hit && pre[i] == M_FREE) begin
          m_state[i] = M_RDY_INI;
          m_id[i]    = int'(bus.new_read_num);
          hit        = 1;
        end
      end
    end

    if (!bus.stall) begin
      hit = 0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        s = (m_rr + k) % NUM_SLOTS;
        if (!hit && (pre[s] == M_RDY_INI || pre[s] == M_RDY_RUN)) begin
          hit            = 1;
          m_issue_id     = m_id[s];
          m_issue_slot   = s;
          m_issue_status = (pre[s] == M_RDY_INI) ? BCK_INI : BCK_RUN;
          m_state[s]     = M_IN_FLIGHT;
          m_rr           = (s + 1) % NUM_SLOTS;
        end
      end
      if (!hit) begin
        m_issue_id     = 0;
        m_issue_slot   = 0;
        m_issue_status = BUBBLE;
      end
    end

    m_done_v = 0;
    if (bus.ret_valid) begin
      s = int'(bus.ret_slot);
      if (pre[s] == M_IN_FLIGHT) begin
        if (bus.ret_done) begin
          m_state[s] = M_FREE;
          m_done_v   = 1;
          m_done_id  = m_id[s];
        end else begin
          m_state[s] = M_RDY_RUN;
        end
      end else begin
        m_perr = 1;
      end
    end

    m_ready = 0;
    for (int i = 0; i < NUM_SLOTS; i++) if (m_state[i] == M_FREE) m_ready = 1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "/status"}, 32'(bus.issue_status), 32'(m_issue_status));
    chk({tag, "/id"}, 32'(bus.issue_read_num), 32'(m_issue_id));
    chk({tag, "/slot"}, 32'(bus.issue_slot), 32'(m_issue_slot));
    chk({tag, "/ready"}, 32'(bus.new_ready), 32'(m_ready));
    chk({tag, "/done_v"}, 32'(bus.done_valid), 32'(m_done_v));
    chk({tag, "/perr"}, 32'(bus.proto_err), 32'(m_perr));
    if (m_done_v) chk({tag, "/done_id"}, 32'(bus.done_read_num), 32'(m_done_id));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic idle();
    bus.stall        = 1'b0;
    bus.new_valid    = 1'b0;
    bus.new_read_num = '0;
    bus.ret_valid    = 1'b0;
    bus.ret_slot     = '0;
    bus.ret_done     = 1'b0;
  endtask

  task automatic drive_alloc(input int id);
    idle();
    bus.new_valid    = 1'b1;
    bus.new_read_num = READ_NUM_WIDTH'(id);
  endtask

  task automatic drive_ret(input int slot, input bit done);
    idle();
    bus.ret_valid = 1'b1;
    bus.ret_slot  = SLOT_W'(slot);
    bus.ret_done  = done;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_model("reset");
    chk("reset/done_id", 32'(bus.done_read_num), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    #2 rst = 1'b0;
    #1;
    check_model("por");
    chk("por/done_id", 32'(bus.done_read_num), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single read: INI, RUN, RUN, then retire.
    drive_alloc(5); tick("s1_alloc"); idle();
    tick("s1_ini");
    chk("s1_ini_status", 32'(bus.issue_status), 32'(BCK_INI));
    chk("s1_ini_id", 32'(bus.issue_read_num), 32'd5);
    drive_ret(0, 0); tick("s1_ret_a"); idle();
    tick("s1_run_a");
    chk("s1_run_a_status", 32'(bus.issue_status), 32'(BCK_RUN));
    drive_ret(0, 0); tick("s1_ret_b"); idle();
    tick("s1_run_b");
    chk("s1_run_b_status", 32'(bus.issue_status), 32'(BCK_RUN));
    chk("s1_run_b_id", 32'(bus.issue_read_num), 32'd5);
    drive_ret(0, 1); tick("s1_retire");
    chk("s1_done_v", 32'(bus.done_valid), 32'd1);
    chk("s1_done_id", 32'(bus.done_read_num), 32'd5);
    idle(); tick("s1_after");
    chk("s1_done_pulse", 32'(bus.done_valid), 32'd0);
    chk("s1_ready", 32'(bus.new_ready), 32'd1);

    // Fill all slots; a fifth offer is ignored.
    for (int i = 1; i <= 4; i++) begin
      drive_alloc(i);
      tick("fill_alloc");
      if (i >= 2) chk("fill_issue_slot", 32'(bus.issue_slot), 32'(i - 2));
    end
    chk("fill_not_ready", 32'(bus.new_ready), 32'd0);
    drive_alloc(9); tick("fill_extra");
    chk("fill_last_slot", 32'(bus.issue_slot), 32'd3);
    chk("fill_last_status", 32'(bus.issue_status), 32'(BCK_INI));
    idle(); tick("fill_idle");
    chk("fill_extra_ignored", 32'(bus.issue_status), 32'(BUBBLE));
    for (int s = 0; s < 4; s++) begin
      drive_ret(s, 1); tick("fill_retire");
      chk("fill_done_id", 32'(bus.done_read_num), 32'(s + 1));
    end
    idle(); tick("fill_empty");

    // Round-robin: slots 0 and 2 ready with rr_ptr at 1.
    for (int i = 0; i < 3; i++) begin drive_alloc(10 + i); tick("rr_alloc"); end
    idle(); tick("rr_issue_last");
    drive_ret(0, 0); tick("rr_ret0");
    drive_ret(2, 0); tick("rr_ret2");
    chk("rr_pre_slot", 32'(bus.issue_slot), 32'd0);
    drive_ret(0, 0); bus.stall = 1'b1; tick("rr_ret0_stalled");
    idle(); tick("rr_first");
    chk("rr_first_slot", 32'(bus.issue_slot), 32'd2);
    chk("rr_first_id", 32'(bus.issue_read_num), 32'd12);
    tick("rr_second");
    chk("rr_second_slot", 32'(bus.issue_slot), 32'd0);
    chk("rr_second_id", 32'(bus.issue_read_num), 32'd10);
    for (int s = 0; s < 3; s++) begin drive_ret(s, 1); tick("rr_retire"); end

    // Stall: slot 1 ready, slot 3 returns mid-stall.
    for (int i = 0; i < 4; i++) begin drive_alloc(20 + i); tick("st_alloc"); end
    drive_ret(1, 0); tick("st_ret1");
    for (int c = 0; c < 3; c++) begin
      idle();
      bus.stall = 1'b1;
      if (c == 1) begin
        bus.ret_valid = 1'b1;
        bus.ret_slot  = SLOT_W'(3);
      end
      tick("st_hold");
      chk("st_hold_slot", 32'(bus.issue_slot), 32'd3);
      chk("st_hold_id", 32'(bus.issue_read_num), 32'd23);
    end
    idle(); tick("st_rel1");
    chk("st_rel1_slot", 32'(bus.issue_slot), 32'd1);
    chk("st_rel1_status", 32'(bus.issue_status), 32'(BCK_RUN));
    tick("st_rel2");
    chk("st_rel2_slot", 32'(bus.issue_slot), 32'd3);

    // Protocol error on a free slot.
    drive_ret(2, 1); tick("pe_free2");
    drive_ret(2, 0); tick("pe_err");
    chk("pe_set", 32'(bus.proto_err), 32'd1);
    chk("pe_no_done", 32'(bus.done_valid), 32'd0);
    idle(); tick("pe_sticky");
    chk("pe_sticky", 32'(bus.proto_err), 32'd1);

    // Async reset with three slots busy, then a stale return.
    apply_reset();
    tick("rs_first");
    chk("rs_bubble", 32'(bus.issue_status), 32'(BUBBLE));
    drive_ret(0, 0); tick("rs_stale");
    chk("rs_stale_perr", 32'(bus.proto_err), 32'd1);
    drive_alloc(30); tick("rs_alloc"); idle();
    tick("rs_issue");
    chk("rs_issue_id", 32'(bus.issue_read_num), 32'd30);
    apply_reset();

    // Randomized traffic; returns only target in-flight slots.
    for (int c = 0; c < 400; c++) begin
      idle();
      bus.stall = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 1) begin
        bus.new_valid    = 1'b1;
        bus.new_read_num = READ_NUM_WIDTH'($urandom);
      end
      n_cand = 0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (m_state[i] == M_IN_FLIGHT) begin
          cand[n_cand] = i;
          n_cand++;
        end
      end
      if (n_cand > 0 && $urandom_range(0, 2) != 0) begin
        bus.ret_valid = 1'b1;
        bus.ret_slot  = SLOT_W'(cand[$urandom_range(0, n_cand - 1)]);
        bus.ret_done  = ($urandom_range(0, 2) == 0);
      end
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
